// File: rtl/bram_rd_seq.sv
// Purpose : sequence one frame of BRAM port-B word reads (line by line) and tag each word with frame/line markers.
// Latency : a word issued with enb in cycle t appears as vld (with its markers) in cycle t+2.
// Backpress: stall holds address/column/line and suppresses enb; the marker pipeline keeps shifting.
//
// Ports
//   clk, rst      : single rising-edge clock, synchronous active-high reset
//   start         : one-cycle frame-read request, only honoured while idle
//   stall         : downstream hold, no read issued in a cycle where it is high
//   addrb, enb    : BRAM port-B word address and read enable
//   vld           : byte-split register downstream holds a requested word this cycle
//   sof/eof/sol/eol: frame/line markers, meaningful only with vld
//   busy, done    : frame in progress / one-cycle completion pulse
module bram_rd_seq #(
    parameter int ADDR_W         = 14,
    parameter int WORDS_PER_LINE = 64,
    parameter int LINES          = 256,
    parameter int BASE_ADDR      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic [ADDR_W-1:0] addrb,
    output logic              enb,
    output logic              vld,
    output logic              sof,
    output logic              eof,
    output logic              sol,
    output logic              eol,
    output logic              busy,
    output logic              done
);

    // Counters need at least one bit even for degenerate 1-word lines / 1-line frames.
    localparam int COL_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WORDS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One marker bundle per issued word, travelling alongside the BRAM data.
    typedef struct packed {
        logic vld;
        logic sof;
        logic eof;
        logic sol;
        logic eol;
    } mark_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;

    logic  issue;
    logic  col_last;
    logic  line_last;
    logic  eof_out;
    mark_t mark_issue;
    mark_t mark_s1;   // aligned with the BRAM output register
    mark_t mark_s2;   // aligned with the byte-split register

    // enb must drop in the very cycle stall rises, so it is decoded from the
    // registered state rather than registered itself.
    assign issue     = (state == READ) && !stall;
    assign enb       = issue;
    assign col_last  = (col == COL_LAST);
    assign line_last = (line == LINE_LAST);

    // Markers are computed from the position of the word being issued now;
    // with a single-word line both sol and eol fall out naturally.
    always_comb begin
        mark_issue     = '0;
        mark_issue.vld = issue;
        mark_issue.sof = issue && (col == '0) && (line == '0);
        mark_issue.eof = issue && col_last && line_last;
        mark_issue.sol = issue && (col == '0);
        mark_issue.eol = issue && col_last;
    end

    // The final word's eof leaving the pipeline is what ends the frame.
    assign eof_out = mark_s2.vld && mark_s2.eof;

    // ------------------------------------------------------------------
    // Sequencer FSM: address / column / line counters, busy and done.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addrb <= BASE;
            col   <= '0;
            line  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // done is still high in the cycle right after completion;
                    // a start landing there belongs to the finished frame.
                    if (start && !done) begin
                        state <= READ;
                        addrb <= BASE;
                        col   <= '0;
                        line  <= '0;
                        busy  <= 1'b1;
                    end
                end

                READ: begin
                    if (issue) begin
                        // Address wraps silently at 2^ADDR_W.
                        addrb <= addrb + ADDR_W'(1);
                        if (col_last) begin
                            col <= '0;
                            if (line_last) begin
                                state <= DRAIN;
                            end else begin
                                line <= line + LINE_W'(1);
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (eof_out) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Two-stage marker pipeline matching BRAM + byte-split latency. It
    // shifts every cycle; stall only throttles what enters it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mark_s1 <= '0;
            mark_s2 <= '0;
        end else begin
            mark_s1 <= mark_issue;
            mark_s2 <= mark_s1;
        end
    end

    assign vld = mark_s2.vld;
    assign sof = mark_s2.sof;
    assign eof = mark_s2.eof;
    assign sol = mark_s2.sol;
    assign eol = mark_s2.eol;

endmodule

// File: tb/tb_bram_rd_seq.sv
// Purpose : self-checking bench for bram_rd_seq, three configurations sharing one stimulus stream.
// Latency : outputs compared every cycle at the falling edge against a word-index level model.
// Backpress: stall driven both in fixed scenarios and randomly.
module tb_bram_rd_seq;

    logic clk;
    logic rst;
    logic start;
    logic stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: 4x2 frame at 0x10; B: 4x1 frame at 0xE with a 4-bit address; C: 1x3 frame.
    logic [7:0] a_addrb;
    logic [3:0] b_addrb;
    logic [7:0] c_addrb;
    logic a_enb, a_vld, a_sof, a_eof, a_sol, a_eol, a_busy, a_done;
    logic b_enb, b_vld, b_sof, b_eof, b_sol, b_eol, b_busy, b_done;
    logic c_enb, c_vld, c_sof, c_eof, c_sol, c_eol, c_busy, c_done;

    bram_rd_seq #(.ADDR_W(8), .WORDS_PER_LINE(4), .LINES(2), .BASE_ADDR(16)) u_a (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .addrb(a_addrb), .enb(a_enb), .vld(a_vld), .sof(a_sof), .eof(a_eof),
        .sol(a_sol), .eol(a_eol), .busy(a_busy), .done(a_done));

    bram_rd_seq #(.ADDR_W(4), .WORDS_PER_LINE(4), .LINES(1), .BASE_ADDR(14)) u_b (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .addrb(b_addrb), .enb(b_enb), .vld(b_vld), .sof(b_sof), .eof(b_eof),
        .sol(b_sol), .eol(b_eol), .busy(b_busy), .done(b_done));

    bram_rd_seq #(.ADDR_W(8), .WORDS_PER_LINE(1), .LINES(3), .BASE_ADDR(5)) u_c (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .addrb(c_addrb), .enb(c_enb), .vld(c_vld), .sof(c_sof), .eof(c_eof),
        .sol(c_sol), .eol(c_eol), .busy(c_busy), .done(c_done));

    typedef struct packed {
        logic [15:0] addrb;
        logic enb, vld, sof, eof, sol, eol, busy, done;
    } obs_t;

    typedef struct {
        int aw, wpl, lines, base;
    } mcfg_t;

    // Model state: frame active, words issued so far (k), word index issued
    // last cycle (p1) and word index on the output this cycle (p2), -1 = none.
    typedef struct {
        bit active;
        int k;
        int p1;
        int p2;
        bit done;
    } mstate_t;

    obs_t    dut_o [3];
    mcfg_t   cfg   [3];
    mstate_t ms    [3];
    int      vcnt  [3];

    assign dut_o[0] = {8'h00, a_addrb, a_enb, a_vld, a_sof, a_eof, a_sol, a_eol, a_busy, a_done};
    assign dut_o[1] = {12'h000, b_addrb, b_enb, b_vld, b_sof, b_eof, b_sol, b_eol, b_busy, b_done};
    assign dut_o[2] = {8'h00, c_addrb, c_enb, c_vld, c_sof, c_eof, c_sol, c_eol, c_busy, c_done};

    int vectors = 0;
    int misc    = 0;
    int cyc     = 0;
    int t0      = 0;
    bit chk_en  = 1'b0;
    bit rec     = 1'b0;

    // Per-cycle event masks (bit n = cycle n after the scenario's first cycle).
    logic [31:0] a_enb_m, a_vld_m, a_sof_m, a_eol_m, a_eof_m, a_done_m, a_busy_m;
    logic [31:0] c_vld_m, c_sof_m, c_eof_m, c_sol_m, c_eol_m, c_done_m;
    int a_aq[$];
    int b_aq[$];
    int a_addr_rel [32];

    function automatic mstate_t reset_state();
        mstate_t x;
        x.active = 1'b0;
        x.k      = 0;
        x.p1     = -1;
        x.p2     = -1;
        x.done   = 1'b0;
        return x;
    endfunction

    function automatic obs_t predict(input mcfg_t c, input mstate_t s, input logic stl);
        obs_t o;
        int   n;
        n = c.wpl * c.lines;
        o = '0;
        o.addrb = 16'((c.base + s.k) % (1 << c.aw));
        o.enb   = s.active && (s.k < n) && !stl;
        o.vld   = (s.p2 >= 0);
        if (o.vld) begin
            o.sof = (s.p2 == 0);
            o.eof = (s.p2 == n - 1);
            o.sol = ((s.p2 % c.wpl) == 0);
            o.eol = ((s.p2 % c.wpl) == c.wpl - 1);
        end
        o.busy = s.active;
        o.done = s.done;
        return o;
    endfunction

    function automatic mstate_t advance(input mcfg_t c, input mstate_t s,
                                        input logic r, input logic st, input logic stl);
        mstate_t x;
        int      n;
        bit      iss;
        n = c.wpl * c.lines;
        if (r) return reset_state();
        iss      = s.active && (s.k < n) && !stl;
        x.p2     = s.p1;
        x.p1     = iss ? s.k : -1;
        x.k      = iss ? s.k + 1 : s.k;
        x.done   = s.active && (s.p2 == n - 1);
        x.active = s.active;
        if (s.active && s.p2 == n - 1) begin
            x.active = 1'b0;
        end else if (!s.active && st && !s.done) begin
            x.active = 1'b1;
            x.k      = 0;
        end
        return x;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misc++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    // Compare process: every falling edge, DUT against model, then advance the model.
    always @(negedge clk) begin
        obs_t e;
        int   rel;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                e = predict(cfg[i], ms[i], stall);
                check($sformatf("addrb[%0d]", i), dut_o[i].addrb, e.addrb);
                check($sformatf("enb[%0d]", i),   dut_o[i].enb,   e.enb);
                check($sformatf("vld[%0d]", i),   dut_o[i].vld,   e.vld);
                check($sformatf("busy[%0d]", i),  dut_o[i].busy,  e.busy);
                check($sformatf("done[%0d]", i),  dut_o[i].done,  e.done);
                if (e.vld) begin
                    check($sformatf("markers[%0d]", i),
                          {dut_o[i].sof, dut_o[i].eof, dut_o[i].sol, dut_o[i].eol},
                          {e.sof, e.eof, e.sol, e.eol});
                end
                if (dut_o[i].vld) vcnt[i]++;
                if (e.done) begin
                    check($sformatf("frame_len[%0d]", i), vcnt[i], cfg[i].wpl * cfg[i].lines);
                    vcnt[i] = 0;
                end
            end
        end
        if (rec) begin
            rel = cyc - t0;
            if (rel >= 0 && rel < 32) begin
                a_enb_m[rel]  = a_enb;   a_vld_m[rel]  = a_vld;  a_sof_m[rel] = a_sof;
                a_eol_m[rel]  = a_eol;   a_eof_m[rel]  = a_eof;  a_done_m[rel] = a_done;
                a_busy_m[rel] = a_busy;  a_addr_rel[rel] = a_addrb;
                c_vld_m[rel]  = c_vld;   c_sof_m[rel]  = c_sof;  c_eof_m[rel] = c_eof;
                c_sol_m[rel]  = c_sol;   c_eol_m[rel]  = c_eol;  c_done_m[rel] = c_done;
                if (a_enb) a_aq.push_back(a_addrb);
                if (b_enb) b_aq.push_back(b_addrb);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (rst) vcnt[i] = 0;
            ms[i] = advance(cfg[i], ms[i], rst, start, stall);
        end
        cyc++;
    end

    // Fixed 32-cycle scenario: bit r of each mask drives that input in cycle r.
    task automatic run_scn(input logic [31:0] st_m, input logic [31:0] sl_m, input logic [31:0] rs_m);
        for (int r = 0; r < 32; r++) begin
            @(posedge clk);
            #1;
            if (r == 0) begin
                a_enb_m = '0; a_vld_m = '0; a_sof_m = '0; a_eol_m = '0; a_eof_m = '0;
                a_done_m = '0; a_busy_m = '0;
                c_vld_m = '0; c_sof_m = '0; c_eof_m = '0; c_sol_m = '0; c_eol_m = '0; c_done_m = '0;
                a_aq.delete();
                b_aq.delete();
                t0  = cyc;
                rec = 1'b1;
            end
            start = st_m[r];
            stall = sl_m[r];
            rst   = rs_m[r];
        end
        @(posedge clk);
        #1;
        rec   = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic check_addr_seq(input string nm, input int q[$], input int exp[]);
        check({nm, "_len"}, q.size(), exp.size());
        for (int j = 0; j < exp.size() && j < q.size(); j++) begin
            check($sformatf("%s_%0d", nm, j), q[j], exp[j]);
        end
    endtask

    initial begin
        int exp_a[];
        int exp_b[];
        cfg[0] = '{aw: 8, wpl: 4, lines: 2, base: 16};
        cfg[1] = '{aw: 4, wpl: 4, lines: 1, base: 14};
        cfg[2] = '{aw: 8, wpl: 1, lines: 3, base: 5};
        for (int i = 0; i < 3; i++) begin
            ms[i]   = reset_state();
            vcnt[i] = 0;
        end
        exp_a = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17};
        exp_b = '{'hE, 'hF, 'h0, 'h1};
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        // Reset state, pinned by hand.
        check("rst_addrb_a", a_addrb, 'h10);
        check("rst_addrb_b", b_addrb, 'hE);
        check("rst_outs_a", {a_enb, a_vld, a_busy, a_done}, 0);
        rst   = 1'b0;
        stall = 1'b0;
        repeat (2) @(posedge clk);

        // Plain frame, no stall.
        run_scn(32'h1, 32'h0, 32'h0);
        check("s1_a_enb",  a_enb_m,  32'h0000_01FE);
        check("s1_a_vld",  a_vld_m,  32'h0000_07F8);
        check("s1_a_sof",  a_sof_m,  32'h0000_0008);
        check("s1_a_eol",  a_eol_m,  32'h0000_0440);
        check("s1_a_eof",  a_eof_m,  32'h0000_0400);
        check("s1_a_done", a_done_m, 32'h0000_0800);
        check("s1_a_busy", a_busy_m, 32'h0000_07FE);
        check_addr_seq("s1_a_addr", a_aq, exp_a);
        check_addr_seq("s1_b_addr", b_aq, exp_b);
        check("s1_c_vld",  c_vld_m,  32'h38);
        check("s1_c_sol",  c_sol_m,  32'h38);
        check("s1_c_eol",  c_eol_m,  32'h38);
        check("s1_c_sof",  c_sof_m,  32'h08);
        check("s1_c_eof",  c_eof_m,  32'h20);
        check("s1_c_done", c_done_m, 32'h40);

        // Stall in cycles 3..5.
        run_scn(32'h1, 32'h38, 32'h0);
        check("s2_a_enb",  a_enb_m,  32'h0000_0FC6);
        check("s2_a_vld",  a_vld_m,  32'h0000_3F18);
        check("s2_a_done", a_done_m, 32'h0000_4000);
        check("s2_a_vcnt", $countones(a_vld_m), 8);
        check("s2_a_hold3", a_addr_rel[3], 'h12);
        check("s2_a_hold5", a_addr_rel[5], 'h12);
        check_addr_seq("s2_a_addr", a_aq, exp_a);

        // Reset in cycle 5 of a running frame, then a fresh frame.
        run_scn(32'h1, 32'h0, 32'h20);
        check("s3_a_enb",  a_enb_m,  32'h3E);
        check("s3_a_vld",  a_vld_m,  32'h38);
        check("s3_a_busy", a_busy_m, 32'h3E);
        check("s3_a_done", a_done_m, 32'h0);
        run_scn(32'h1, 32'h0, 32'h0);
        check("s3b_a_vld",  a_vld_m,  32'h0000_07F8);
        check("s3b_a_done", a_done_m, 32'h0000_0800);
        check_addr_seq("s3b_a_addr", a_aq, exp_a);

        // Extra starts in READ (cycle 4) and in the done cycle (11) are ignored.
        run_scn(32'h811, 32'h0, 32'h0);
        check("s4_a_enb",  a_enb_m,  32'h0000_01FE);
        check("s4_a_vld",  a_vld_m,  32'h0000_07F8);
        check("s4_a_done", a_done_m, 32'h0000_0800);

        // Randomized traffic against the model.
        for (int r = 0; r < 4000; r++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        stall = 1'b0;
        rst   = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule

// File: doc/bram_rd_seq.md
BRAM_RD_SEQ -- requirements
Module: bram_rd_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: width of BRAM port-B address.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 64: 32-bit words per image line (4 pixels per word).
REQ-003 SHALL have parameter LINES, default 256: image lines per frame.
REQ-004 SHALL have parameter BASE_ADDR, default 0: word address of the first frame word.
REQ-005 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1: one-cycle frame-read request.
REQ-008 SHALL have port stall  input  1: downstream hold; no new read issued while high.
REQ-009 SHALL have port addrb  output  ADDR_W: BRAM port-B word address.
REQ-010 SHALL have port enb  output  1: BRAM port-B read enable.
REQ-011 SHALL have port vld  output  1: high in the cycle the 4 byte lanes o1..o4 of the downstream byte-split register hold a requested word.
REQ-012 SHALL have ports sof, eof, sol, eol  output  1 each: frame/line markers, qualified by vld.
REQ-013 SHALL have port busy  output  1: high from the cycle after an accepted start until done.
REQ-014 SHALL have port done  output  1: one-cycle pulse at frame completion.

Function
REQ-015 SHALL implement FSM states IDLE, READ, DRAIN.
REQ-016 IDLE: start=1 -> READ next cycle; col=0, line=0, addrb=BASE_ADDR; start ignored in READ/DRAIN.
REQ-017 READ: each cycle with stall=0 -> enb=1, one word issued at addrb, then addrb+1 and col+1.
REQ-018 READ: stall=1 -> enb=0; addrb, col, line held.
REQ-019 col SHALL wrap WORDS_PER_LINE-1 -> 0 with line+1; issuing word (LINES-1, WORDS_PER_LINE-1) -> DRAIN.
REQ-020 addrb arithmetic SHALL be modulo 2^ADDR_W (wraps silently).
REQ-021 Read latency: word issued with enb=1 in cycle t SHALL assert vld in cycle t+2 (1 cycle BRAM + 1 cycle byte-split register).
REQ-022 Marker pipeline (vld, sof, eof, sol, eol) SHALL be 2 stages deep, shifting every cycle regardless of stall.
REQ-023 Markers per issued word: sof at (0,0); eof at (LINES-1, WORDS_PER_LINE-1); sol at col=0; eol at col=WORDS_PER_LINE-1.
REQ-024 When WORDS_PER_LINE=1, sol and eol SHALL both assert on every word.
REQ-025 DRAIN: SHALL wait until the vld with eof has been output, then return to IDLE.
REQ-026 done SHALL pulse in the cycle after the vld carrying eof; busy SHALL deassert in that same cycle.
REQ-027 Exactly WORDS_PER_LINE*LINES vld pulses per frame; no duplicates, none dropped under stall.
REQ-028 start in the cycle done is high SHALL be ignored; start is accepted only in IDLE.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, addrb=BASE_ADDR, enb=0, vld=sof=eof=sol=eol=0, busy=0, done=0, col=line=0.
REQ-030 rst mid-frame SHALL abort: in-flight marker pipeline cleared, no vld/done emitted for the aborted frame.
REQ-031 rst SHALL take priority over start and stall in the same cycle.

Verification
REQ-032 WORDS_PER_LINE=4, LINES=2, BASE_ADDR=0x10, start at cycle 0, stall=0 -> enb cycles 1-8, addrb 0x10..0x17, vld cycles 3-10, sof at 3, eol at 6 and 10, eof at 10, done at 11.
REQ-033 Same config, stall=1 cycles 3-5 -> enb low 3-5, addrb held at 0x12, vld gap at 5-7, total 8 vld pulses, done at 14.
REQ-034 ADDR_W=4, BASE_ADDR=0xE, 4x1 frame -> addrb sequence 0xE, 0xF, 0x0, 0x1.
REQ-035 rst asserted at cycle 5 of a running frame -> from cycle 6 enb=0, vld=0, busy=0, no done; a new start then yields a complete frame from BASE_ADDR.
REQ-036 start pulsed during READ and in the done cycle -> ignored, a single frame of vld pulses only.
REQ-037 WORDS_PER_LINE=1, LINES=3 -> 3 vld pulses, each with sol=eol=1; sof on first, eof on last.
